// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the 8x16 register file / shifter / ALU datapath.
// Moore FSM with registered control strobes; IR-derived fields are decoded combinationally.
module datapath_ctrl #(
  parameter int NREG_BITS = 3,
  parameter int DW        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 s,
  input  logic [DW-1:0]        in,
  output logic                 w,
  output logic [NREG_BITS-1:0] r_addr,
  output logic [NREG_BITS-1:0] w_addr,
  output logic                 w_en,
  output logic                 vsel,
  output logic [DW-1:0]        sximm8,
  output logic                 loada,
  output logic                 loadb,
  output logic                 loadc,
  output logic                 loads,
  output logic                 asel,
  output logic                 bsel,
  output logic [1:0]           shift,
  output logic [1:0]           alu_op,
  output logic                 bad_op
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_EXEC      = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [DW-1:0]  ir;

  logic [2:0]           opcode;
  logic [1:0]           op;
  logic [NREG_BITS-1:0] rn;
  logic [NREG_BITS-1:0] rd;
  logic [NREG_BITS-1:0] rm;
  logic                 is_mov_imm;
  logic                 is_mov_reg;
  logic                 is_alu;
  logic                 is_cmp;
  logic                 is_mvn;
  logic                 is_legal;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_legal   = is_mov_imm || is_mov_reg || is_alu;

  // IR-derived datapath fields stay valid in every state
  assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};
  assign shift  = ir[4:3];
  assign alu_op = is_mov_reg ? 2'b00 : op;
  assign bsel   = 1'b0;
  assign r_addr = (state == S_GET_B) ? rm : rn;
  assign w_addr = is_mov_imm ? rn : rd;

  // Next-state selection
  always_comb begin
    state_next = S_WAIT;
    case (state)
      S_WAIT:      state_next = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (is_mov_imm)              state_next = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn) state_next = S_GET_B;
        else if (is_alu)             state_next = S_GET_A;
        else                         state_next = S_WAIT;
      end
      S_WRITE_IMM: state_next = S_WAIT;
      S_GET_A:     state_next = S_GET_B;
      S_GET_B:     state_next = S_EXEC;
      S_EXEC:      state_next = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_next = S_WAIT;
      default:     state_next = S_WAIT;
    endcase
  end

  // State, IR, sticky error flag and strobes registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_WAIT;
      ir     <= {DW{1'b0}};
      bad_op <= 1'b0;
      w      <= 1'b1;
      w_en   <= 1'b0;
      vsel   <= 1'b0;
      loada  <= 1'b0;
      loadb  <= 1'b0;
      loadc  <= 1'b0;
      loads  <= 1'b0;
      asel   <= 1'b0;
    end else begin
      state <= state_next;
      if (load && (state == S_WAIT)) begin
        ir <= in;
      end
      if ((state == S_WAIT) && s) begin
        bad_op <= 1'b0;
      end else if ((state == S_DECODE) && !is_legal) begin
        bad_op <= 1'b1;
      end
      w     <= (state_next == S_WAIT);
      w_en  <= (state_next == S_WRITE_IMM) || (state_next == S_WRITE_REG);
      vsel  <= (state_next == S_WRITE_IMM);
      loada <= (state_next == S_GET_A);
      loadb <= (state_next == S_GET_B);
      loadc <= (state_next == S_EXEC) && !is_cmp;
      loads <= (state_next == S_EXEC) && is_cmp;
      asel  <= (state_next == S_EXEC) && (is_mov_reg || is_mvn);
    end
  end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Moore FSM that sequences the 8x16 register file, the A/B/C operand registers, the shifter and the ALU, one 16-bit instruction at a time.
- Holds an internal instruction register (IR) and decodes it.
- Drives the register-file addresses and write enable, plus every datapath load/select line.
- Sits between the instruction source (switches/testbench) and the datapath; one transaction per `s` pulse.

Parameters:
- NREG_BITS, 3, register address width (8 registers)
- DW, 16, data/instruction width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- load  in  1  capture `in` into IR (honoured only while `w`=1)
- s  in  1  start; sampled only in WAIT
- in  in  16  instruction word
- w  out  1  idle/ready flag; 1 only in WAIT
- r_addr  out  3  regfile read address
- w_addr  out  3  regfile write address
- w_en  out  1  regfile write enable
- vsel  out  1  writeback mux: 0 = C register, 1 = sximm8
- sximm8  out  16  sign-extended IR[7:0]
- loada, loadb, loadc, loads  out  1 each  operand/result/status register loads
- asel  out  1  1 forces ALU A input to 0
- bsel  out  1  tied 0 (sximm5 path unused this revision)
- shift  out  2  shifter op = IR[4:3]
- alu_op  out  2  ALU op
- bad_op  out  1  sticky illegal-opcode flag

Behaviour:
- Encoding: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Supported instructions:
  - 110/10: MOV Rn,#imm8
  - 110/00: MOV Rd,Rm{,sh}
  - 101/00: ADD Rd,Rn,Rm{,sh}
  - 101/01: CMP Rn,Rm{,sh}
  - 101/10: AND Rd,Rn,Rm{,sh}
  - 101/11: MVN Rd,Rm{,sh}
- Reset (async, any state):
  - state = WAIT, IR = 0, bad_op = 0.
  - All loads, w_en and asel = 0; w = 1.
- IR: loads `in` on the rising edge when load=1 and state=WAIT; ignored otherwise.
- Same edge with load=1 and s=1 in WAIT: IR takes the new word, state goes to DECODE, and decode uses the new word.
- States (Moore outputs; unlisted outputs are 0):
  - WAIT: w=1. s=1 -> DECODE and clear bad_op; else stay.
  - DECODE:
    - MOV imm -> WRITE_IMM
    - MOV reg / MVN -> GET_B
    - ADD / CMP / AND -> GET_A
    - any other encoding -> WAIT and set bad_op=1, with no write
  - WRITE_IMM: w_addr=Rn, vsel=1, w_en=1 -> WAIT.
  - GET_A: r_addr=Rn, loada=1 -> GET_B.
  - GET_B: r_addr=Rm, loadb=1 -> EXEC.
  - EXEC:
    - shift=sh in every state for these instructions.
    - alu_op: 00 for MOV reg, IR[12:11] otherwise.
    - asel=1 for MOV reg and MVN.
    - CMP: loads=1 -> WAIT.
    - Others: loadc=1 -> WRITE_REG.
  - WRITE_REG: w_addr=Rd, vsel=0, w_en=1 -> WAIT.
- Busy cycles with w=0, counted from the edge that samples s:
  - MOV imm: 2
  - MOV reg / MVN / CMP: 4
  - ADD / AND: 5
  - illegal: 1
- Regfile write occurs on the edge leaving WRITE_IMM/WRITE_REG; the value is readable on r_data the following cycle.
- s held high continuously: a new transaction starts on the first edge back in WAIT, re-executing IR.
- Reset mid-transaction: aborts immediately; no w_en occurs afterwards, and a partial A/B load is harmless.
- sximm8 and address outputs are combinational from IR; they remain valid in all states.
- w_en is never asserted outside WRITE_IMM/WRITE_REG; at most one write per transaction.

Test Plan:
- Reset then idle: after reset, w=1, w_en=0, bad_op=0. Toggle s with IR=0 (opcode 000): bad_op=1 after 1 busy cycle, no w_en.
- MOV R1,#-128 (in=16'hD180), load+s same edge: DECODE, then WRITE_IMM with w_addr=1, vsel=1, w_en=1, sximm8=16'hFF80. w=1 again 2 cycles later.
- ADD R2,R1,R0 LSL#1 (in=16'hA148): states GET_A (r_addr=1, loada), GET_B (r_addr=0, loadb, shift=01), EXEC (alu_op=00, loadc), WRITE_REG (w_addr=2, w_en). w=0 for exactly 5 cycles.
- CMP R3,R4 (in=16'hAB04): loads=1 in EXEC, w_en never asserted, 4 busy cycles. MVN R5,R6 (in=16'hB8A6): asel=1 and alu_op=11 in EXEC, write to R5.
- Assert reset during EXEC of ADD: state returns to WAIT asynchronously (before next edge), no write on any following edge. load while busy: IR unchanged (check w_addr).
- s held high across two transactions: second DECODE follows WAIT by one cycle, same IR re-executed.
